hazard_sb: RTL and testbench

Parametrised hazard, forwarding and scoreboard unit for the in-order core. It replaces fixed EX/MEM/WB hazard decoding with a per-stage producer tracker of configurable depth. Each issuing instruction carries a per-instruction result-ready stage, and a register scoreboard tracks results from long-latency units (mul/div, AMO) that complete outside the pipeline. It sits beside the ID stage: it gates issue, inserts bubbles and drives the EX operand-forwarding muxes.

---
 rtl/hazard_sb.sv | 160 ++++++++++++++++
 tb/tb_hazard_sb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sb.sv
// hazard_sb: RAW/WAW hazard detection, EX operand-forwarding select and
// long-latency register scoreboard for the in-order core. The unit sits
// beside ID. It follows the writers in the NFW stages after ID, and a busy
// bit per register covers results from units that finish outside the pipe.
module hazard_sb #(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int NFW  = 3,
  parameter int SW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_ext,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          id_rs1_en,
  input  logic [RW-1:0] id_rs1,
  input  logic          id_rs2_en,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rd_en,
  input  logic [RW-1:0] id_rd,
  input  logic [SW-1:0] id_rdy_stage,
  input  logic          id_long,
  input  logic          lo_done,
  input  logic [RW-1:0] lo_rd,
  output logic          stall_id,
  output logic          issue,
  output logic          fw_a_en,
  output logic [SW-1:0] fw_a_sel,
  output logic          fw_b_en,
  output logic [SW-1:0] fw_b_sel,
  output logic          pipe_empty
);

  // Tracker: entry k describes the instruction now in stage k after ID
  // (0 = EX). wr is set only for in-pipe writers of a nonzero rd.
  logic [NFW-1:0]         ent_v;
  logic [NFW-1:0]         ent_wr;
  logic [NFW-1:0][RW-1:0] ent_rd;
  logic [NFW-1:0][SW-1:0] ent_rdy;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic          a_fw, a_stall, b_fw, b_stall;
  logic [SW-1:0] a_sel, b_sel;
  logic          sb_stall, hazard;
  logic          rd_nz;

  assign rd_nz = id_rd_en && (id_rd != '0);

  // Find the youngest in-flight writer of each source. Classify it as a
  // forward (the result exists by the time the consumer reaches EX), a RAW
  // stall, or no hazard (no writer, or it is already in the write-first
  // regfile stage).
  always_comb begin
    int            ka, kb;
    logic [SW-1:0] ra, rb;
    ka = -1;
    kb = -1;
    ra = '0;
    rb = '0;
    for (int k = NFW-1; k >= 0; k--) begin
      if (ent_v[k] && ent_wr[k] && ent_rd[k] == id_rs1) begin
        ka = k;
        ra = ent_rdy[k];
      end
      if (ent_v[k] && ent_wr[k] && ent_rd[k] == id_rs2) begin
        kb = k;
        rb = ent_rdy[k];
      end
    end
    a_fw    = 1'b0;
    a_stall = 1'b0;
    a_sel   = '0;
    b_fw    = 1'b0;
    b_stall = 1'b0;
    b_sel   = '0;
    if (id_rs1_en && id_rs1 != '0 && ka >= 0 && ka + 1 < NFW) begin
      if (ka + 1 > int'(ra)) begin
        a_fw  = 1'b1;
        a_sel = SW'(ka + 1);
      end else begin
        a_stall = 1'b1;
      end
    end
    if (id_rs2_en && id_rs2 != '0 && kb >= 0 && kb + 1 < NFW) begin
      if (kb + 1 > int'(rb)) begin
        b_fw  = 1'b1;
        b_sel = SW'(kb + 1);
      end else begin
        b_stall = 1'b1;
      end
    end
  end

  // Scoreboard stalls: a source that is still owed by a long unit, or a new
  // writer of a register that a long unit has yet to write (WAW).
  always_comb begin
    sb_stall = 1'b0;
    if (id_rs1_en && busy[id_rs1]) sb_stall = 1'b1;
    if (id_rs2_en && busy[id_rs2]) sb_stall = 1'b1;
    if (rd_nz && busy[id_rd])      sb_stall = 1'b1;
  end

  assign hazard     = a_stall || b_stall || sb_stall;
  assign stall_id   = stall_ext || (id_valid && !flush && hazard);
  assign issue      = id_valid && !flush && !stall_id;
  assign pipe_empty = !(|(ent_v & ent_wr)) && !(|busy);

  // Next busy vector: long issue sets, completion clears (also when frozen).
  always_comb begin
    busy_nxt = busy;
    if (issue && id_long && rd_nz) busy_nxt[id_rd] = 1'b1;
    if (lo_done)                   busy_nxt[lo_rd] = 1'b0;
  end

  // Advance the tracker and forward selects unless frozen. A non-issuing
  // cycle shifts in a bubble and drops forward enables but keeps the selects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_v    <= '0;
      ent_wr   <= '0;
      ent_rd   <= '0;
      ent_rdy  <= '0;
      fw_a_en  <= 1'b0;
      fw_a_sel <= '0;
      fw_b_en  <= 1'b0;
      fw_b_sel <= '0;
    end else if (!stall_ext) begin
      for (int k = NFW-1; k > 0; k--) begin
        ent_v[k]   <= ent_v[k-1];
        ent_wr[k]  <= ent_wr[k-1];
        ent_rd[k]  <= ent_rd[k-1];
        ent_rdy[k] <= ent_rdy[k-1];
      end
      ent_v[0] <= issue;
      if (issue) begin
        ent_wr[0]  <= rd_nz && !id_long;
        ent_rd[0]  <= id_rd;
        ent_rdy[0] <= id_rdy_stage;
        fw_a_en    <= a_fw;
        fw_a_sel   <= a_sel;
        fw_b_en    <= b_fw;
        fw_b_sel   <= b_sel;
      end else begin
        ent_wr[0] <= 1'b0;
        fw_a_en   <= 1'b0;
        fw_b_en   <= 1'b0;
      end
    end
  end

  // Scoreboard register; reset drops any long op still outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed instruction sequences with literal
// expectations, and a distance-based reference model checked every cycle.
module tb_hazard_sb;
  localparam int NFW = 3;

  logic       clk, rst_n, stall_ext, flush, id_valid;
  logic       id_rs1_en, id_rs2_en, id_rd_en, id_long, lo_done;
  logic [4:0] id_rs1, id_rs2, id_rd, lo_rd;
  logic [1:0] id_rdy_stage;
  logic       stall_id, issue, fw_a_en, fw_b_en, pipe_empty;
  logic [1:0] fw_a_sel, fw_b_sel;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 0;

  hazard_sb #(.NREG(32), .RW(5), .NFW(NFW), .SW(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext), .flush(flush),
    .id_valid(id_valid), .id_rs1_en(id_rs1_en), .id_rs1(id_rs1),
    .id_rs2_en(id_rs2_en), .id_rs2(id_rs2), .id_rd_en(id_rd_en), .id_rd(id_rd),
    .id_rdy_stage(id_rdy_stage), .id_long(id_long), .lo_done(lo_done), .lo_rd(lo_rd),
    .stall_id(stall_id), .issue(issue), .fw_a_en(fw_a_en), .fw_a_sel(fw_a_sel),
    .fw_b_en(fw_b_en), .fw_b_sel(fw_b_sel), .pipe_empty(pipe_empty)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: instructions indexed by how many slots ago they left ID
  // (slot d-1 holds the one that left d slots ago).
  bit         mv[NFW];
  bit         mwr[NFW];
  logic [4:0] mrd[NFW];
  logic [1:0] mrdy[NFW];
  bit         mbusy[32];
  bit         mfa_en, mfb_en;
  logic [1:0] mfa_sel, mfb_sel;

  function automatic void m_src(input logic en, input logic [4:0] rs,
                                output bit st, output bit fw, output logic [1:0] sel);
    st = 0; fw = 0; sel = 0;
    if (en && rs != 0) begin
      for (int d = 1; d <= NFW; d++) begin
        if (mv[d-1] && mwr[d-1] && mrd[d-1] == rs) begin
          if (d < NFW) begin
            if (d > mrdy[d-1]) begin fw = 1; sel = d[1:0]; end
            else st = 1;
          end
          break;
        end
      end
      if (mbusy[rs]) st = 1;
    end
  endfunction

  function automatic void m_eval(output bit st, output bit is,
                                 output bit fa, output logic [1:0] sa,
                                 output bit fb, output logic [1:0] sb);
    bit s1, s2, waw;
    m_src(id_rs1_en, id_rs1, s1, fa, sa);
    m_src(id_rs2_en, id_rs2, s2, fb, sb);
    waw = id_rd_en && id_rd != 0 && mbusy[id_rd];
    st = stall_ext || (id_valid && !flush && (s1 || s2 || waw));
    is = id_valid && !flush && !st;
  endfunction

  function automatic bit m_empty();
    for (int k = 0; k < NFW; k++) if (mv[k] && mwr[k]) return 0;
    for (int r = 0; r < 32; r++) if (mbusy[r]) return 0;
    return 1;
  endfunction

  // Model state update on each clock edge.
  always @(posedge clk) begin
    bit u_st, u_is, u_fa, u_fb;
    logic [1:0] u_sa, u_sb;
    if (!rst_n) begin
      for (int k = 0; k < NFW; k++) begin mv[k] = 0; mwr[k] = 0; mrd[k] = 0; mrdy[k] = 0; end
      for (int r = 0; r < 32; r++) mbusy[r] = 0;
      mfa_en = 0; mfb_en = 0; mfa_sel = 0; mfb_sel = 0;
    end else begin
      m_eval(u_st, u_is, u_fa, u_sa, u_fb, u_sb);
      if (lo_done) mbusy[lo_rd] = 0;
      if (!stall_ext) begin
        for (int k = NFW-1; k > 0; k--) begin
          mv[k] = mv[k-1]; mwr[k] = mwr[k-1]; mrd[k] = mrd[k-1]; mrdy[k] = mrdy[k-1];
        end
        if (u_is) begin
          mv[0] = 1; mwr[0] = id_rd_en && id_rd != 0 && !id_long;
          mrd[0] = id_rd; mrdy[0] = id_rdy_stage;
          mfa_en = u_fa; mfa_sel = u_sa; mfb_en = u_fb; mfb_sel = u_sb;
          if (id_long && id_rd_en && id_rd != 0) mbusy[id_rd] = 1;
        end else begin
          mv[0] = 0; mwr[0] = 0;
          mfa_en = 0; mfb_en = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e_st, e_is, e_fa, e_fb;
    logic [1:0] e_sa, e_sb;
    if (chk_on) begin
      m_eval(e_st, e_is, e_fa, e_sa, e_fb, e_sb);
      chk("m_stall_id", stall_id, e_st);
      chk("m_issue", issue, e_is);
      chk("m_fw_a_en", fw_a_en, mfa_en);
      chk("m_fw_a_sel", fw_a_sel, mfa_sel);
      chk("m_fw_b_en", fw_b_en, mfb_en);
      chk("m_fw_b_sel", fw_b_sel, mfb_sel);
      chk("m_pipe_empty", pipe_empty, m_empty());
    end
  end

  // Present an instruction in ID (called at posedge+2) and hold it until it
  // issues; returns the number of cycles it was held.
  task automatic issue_ins(input logic r1e, input logic [4:0] r1,
                           input logic r2e, input logic [4:0] r2,
                           input logic rde, input logic [4:0] rd,
                           input logic [1:0] rdy, input logic lng, output int ns);
    id_valid = 1; id_rs1_en = r1e; id_rs1 = r1; id_rs2_en = r2e; id_rs2 = r2;
    id_rd_en = rde; id_rd = rd; id_rdy_stage = rdy; id_long = lng;
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (issue) begin
        @(posedge clk); #2;
        id_valid = 0;
        return;
      end
      ns++;
      @(posedge clk); #2;
    end
    nchk++; nerr++;
    $display("FAIL issue_timeout: instruction rd=%0d still held after %0d cycles", rd, ns);
    id_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int ns, bad;

  initial begin
    rst_n = 0; stall_ext = 0; flush = 0; id_valid = 0;
    id_rs1_en = 0; id_rs1 = 0; id_rs2_en = 0; id_rs2 = 0;
    id_rd_en = 0; id_rd = 0; id_rdy_stage = 0; id_long = 0;
    lo_done = 0; lo_rd = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1; chk_on = 1;
    #1;
    chk("rst_stall_id", stall_id, 0);
    chk("rst_issue", issue, 0);
    chk("rst_pipe_empty", pipe_empty, 1);
    chk("rst_fw_a_en", fw_a_en, 0);
    chk("rst_fw_b_sel", fw_b_sel, 0);
    idle(1);

    // ALU back-to-back: add x5; add x6,x5,x1
    issue_ins(1, 1, 1, 2, 1, 5, 0, 0, ns);  chk("alu_prod_stall", ns, 0);
    issue_ins(1, 5, 1, 1, 1, 6, 0, 0, ns);  chk("alu_cons_stall", ns, 0);
    #1;
    chk("alu_fw_a_en", fw_a_en, 1);
    chk("alu_fw_a_sel", fw_a_sel, 1);
    chk("alu_fw_b_en", fw_b_en, 0);
    idle(3);

    // Load-use: lw x5; consumer rs2=x5
    issue_ins(1, 1, 0, 0, 1, 5, 1, 0, ns);
    issue_ins(1, 3, 1, 5, 1, 8, 0, 0, ns);  chk("lu_stall_cycles", ns, 1);
    #1;
    chk("lu_fw_b_en", fw_b_en, 1);
    chk("lu_fw_b_sel", fw_b_sel, 2);
    chk("lu_fw_a_en", fw_a_en, 0);
    idle(3);

    // Load-use with one independent instruction between
    issue_ins(1, 1, 0, 0, 1, 5, 1, 0, ns);
    issue_ins(1, 1, 1, 2, 1, 9, 0, 0, ns);
    issue_ins(0, 0, 1, 5, 1, 8, 0, 0, ns);  chk("lu_gap_stall", ns, 0);
    #1;
    chk("lu_gap_fw_b_en", fw_b_en, 1);
    chk("lu_gap_fw_b_sel", fw_b_sel, 2);
    idle(3);

    // Distance 3: regfile path
    issue_ins(1, 1, 0, 0, 1, 5, 0, 0, ns);
    issue_ins(1, 1, 0, 0, 1, 10, 0, 0, ns);
    issue_ins(1, 1, 0, 0, 1, 11, 0, 0, ns);
    issue_ins(1, 5, 0, 0, 1, 12, 0, 0, ns); chk("dist3_stall", ns, 0);
    #1;
    chk("dist3_fw_a_en", fw_a_en, 0);
    idle(3);

    // Long op: div x7, consumer rs1=x7 waits for lo_done 10 cycles later
    issue_ins(1, 1, 1, 2, 1, 7, 0, 1, ns);  chk("long_prod_stall", ns, 0);
    id_valid = 1; id_rs1_en = 1; id_rs1 = 7; id_rs2_en = 0; id_rd_en = 0; id_long = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (issue || pipe_empty) bad++;
      @(posedge clk); #2;
    end
    chk("long_wait_leaks", bad, 0);
    lo_done = 1; lo_rd = 7;
    #1;
    chk("long_done_cycle_stall", stall_id, 1);
    chk("long_done_cycle_empty", pipe_empty, 0);
    @(posedge clk); #2;
    lo_done = 0;
    #1;
    chk("long_issue_after", issue, 1);
    chk("long_empty_after", pipe_empty, 1);
    @(posedge clk); #2;
    id_valid = 0;
    #1;
    chk("long_fw_a_en", fw_a_en, 0);
    idle(3);

    // Freeze during load-use, lo_done inside the freeze
    issue_ins(1, 1, 0, 0, 1, 12, 0, 1, ns);
    issue_ins(1, 1, 0, 0, 1, 5, 1, 0, ns);
    id_valid = 1; id_rs1_en = 0; id_rs2_en = 1; id_rs2 = 5; id_rd_en = 0; id_long = 0;
    stall_ext = 1;
    #1;
    chk("frz_stall_id", stall_id, 1);
    @(posedge clk); #2;
    lo_done = 1; lo_rd = 12;
    @(posedge clk); #2;
    lo_done = 0;
    @(posedge clk); #2;
    stall_ext = 0;
    #1;
    chk("frz_hazard_after", issue, 0);
    @(posedge clk); #2;
    #1;
    chk("frz_issue", issue, 1);
    @(posedge clk); #2;
    id_valid = 0;
    #1;
    chk("frz_fw_b_en", fw_b_en, 1);
    chk("frz_fw_b_sel", fw_b_sel, 2);
    idle(1);
    issue_ins(1, 12, 0, 0, 0, 0, 0, 0, ns); chk("frz_busy_cleared", ns, 0);
    idle(3);

    // x0 and disabled sources never stall
    issue_ins(1, 1, 0, 0, 1, 5, 1, 0, ns);
    issue_ins(0, 5, 1, 0, 0, 0, 0, 0, ns);  chk("x0_rsen_stall", ns, 0);
    idle(3);

    // Flush during a hazard
    issue_ins(1, 1, 0, 0, 1, 5, 1, 0, ns);
    id_valid = 1; id_rs1_en = 1; id_rs1 = 5; id_rs2_en = 0; id_rd_en = 0; flush = 1;
    #1;
    chk("flush_issue", issue, 0);
    chk("flush_stall_id", stall_id, 0);
    @(posedge clk); #2;
    flush = 0; id_valid = 0;
    #1;
    chk("flush_fw_a_en", fw_a_en, 0);
    idle(3);

    // Reset mid-operation, with stall_ext high
    issue_ins(1, 1, 0, 0, 1, 7, 0, 1, ns);
    issue_ins(1, 1, 0, 0, 1, 9, 1, 0, ns);
    issue_ins(1, 1, 0, 0, 1, 10, 0, 0, ns);
    rst_n = 0; stall_ext = 1;
    #1;
    chk("rstm_stall_id", stall_id, 1);
    chk("rstm_pre_empty", pipe_empty, 0);
    @(posedge clk); #2;
    rst_n = 1; stall_ext = 0;
    #1;
    chk("rstm_pipe_empty", pipe_empty, 1);
    chk("rstm_fw_a_en", fw_a_en, 0);
    idle(1);
    issue_ins(1, 7, 0, 0, 0, 0, 0, 0, ns);  chk("rstm_busy_gone", ns, 0);
    #1;
    chk("rstm_cons_fw_a_en", fw_a_en, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
